// File: rtl/xmpl_sram_pkg.sv
// rtl/xmpl_sram_pkg.sv - shared constants and types for the SRAM arbiter
package xmpl_sram_pkg;

  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 32;

  // IDLE arbitrates round-robin; LOCKED keeps the grant with one owner
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // One registered SRAM command beat
  typedef struct packed {
    logic                   en;
    logic                   rw;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/xmpl_sram_arbiter_if.sv
// rtl/xmpl_sram_arbiter_if.sv - requester-side command/response bus of the SRAM arbiter
interface xmpl_sram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_rw_i;
  logic [NUM_REQ-1:0]        req_lock_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_data_o;

  // Requesters drive commands and receive accepts and read data
  modport master (
    output req_valid_i, req_rw_i, req_lock_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  // The arbiter consumes commands and returns accepts and read data
  modport slave (
    input  req_valid_i, req_rw_i, req_lock_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

endinterface

// File: rtl/xmpl_rr_picker.sv
// rtl/xmpl_rr_picker.sv - combinational one-hot round-robin pick from a start pointer
module xmpl_rr_picker #(
  parameter  int NUM_REQ = 3,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               found_o
);

  // One extra bit so ptr + offset can be wrapped without overflow
  logic [PTR_W:0] k;

  // Scan from ptr_i upward, wrapping modulo NUM_REQ; first set request wins
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    k       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (k >= (PTR_W+1)'(NUM_REQ)) begin
        k = k - (PTR_W+1)'(NUM_REQ);
      end
      if (!found_o && req_i[k[PTR_W-1:0]]) begin
        found_o               = 1'b1;
        gnt_o[k[PTR_W-1:0]]   = 1'b1;
        idx_o                 = k[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/xmpl_sram_arbiter.sv
// rtl/xmpl_sram_arbiter.sv - round-robin SRAM arbiter with bounded locked bursts
module xmpl_sram_arbiter
  import xmpl_sram_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  xmpl_sram_arbiter_if.slave bus,
  output logic              sram_en_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_rw_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  sram_cmd_t         cmd_q, cmd_d;
  logic [PTR_W-1:0]  cmd_owner_q, cmd_owner_d;
  logic              rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0]  rd_owner_q, rd_owner_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win_idx;
  logic               last_beat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  xmpl_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (bus.req_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // The owner's current beat is the LOCK_MAX-th of its burst
  assign last_beat = ({1'b0, beat_cnt_q} + 9'd1) >= 9'(LOCK_MAX);

  // Arbitration FSM: pick a winner, track lock ownership and burst length
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant      = '0;
    win_idx    = pick_idx;
    case (state_q)
      IDLE: begin
        grant = pick_gnt;
        if (pick_found) begin
          if (bus.req_lock_i[pick_idx]) begin
            state_d    = LOCKED;
            owner_d    = pick_idx;
            beat_cnt_d = 8'd1;
          end else begin
            rr_ptr_d = ptr_inc(pick_idx);
          end
        end
      end
      LOCKED: begin
        win_idx = owner_q;
        if (bus.req_valid_i[owner_q]) begin
          grant[owner_q] = 1'b1;
          if (bus.req_lock_i[owner_q] && !last_beat) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end else begin
            state_d    = IDLE;
            rr_ptr_d   = ptr_inc(owner_q);
            beat_cnt_d = '0;
          end
        end else begin
          // Owner went idle: release without granting anyone this cycle
          state_d    = IDLE;
          rr_ptr_d   = ptr_inc(owner_q);
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register the accepted beat as the next SRAM command and pipeline the read tag
  always_comb begin
    cmd_d       = cmd_q;
    cmd_d.en    = 1'b0;
    cmd_owner_d = cmd_owner_q;
    if (|grant) begin
      cmd_d.en    = 1'b1;
      cmd_owner_d = win_idx;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (win_idx == PTR_W'(k)) begin
          cmd_d.rw    = bus.req_rw_i[k];
          cmd_d.addr  = bus.req_addr_i[k*ADDR_W +: ADDR_W];
          cmd_d.wdata = bus.req_wdata_i[k*DATA_W +: DATA_W];
        end
      end
    end
    rd_valid_d = cmd_q.en & ~cmd_q.rw;
    rd_owner_d = cmd_owner_q;
  end

  // State, pointer, command and read-tag registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      cmd_q       <= '0;
      cmd_owner_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_owner_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      cmd_q       <= cmd_d;
      cmd_owner_q <= cmd_owner_d;
      rd_valid_q  <= rd_valid_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // Read data goes back one-hot to whichever requester issued the read
  always_comb begin
    bus.rsp_valid_o = '0;
    if (rd_valid_q) begin
      bus.rsp_valid_o[rd_owner_q] = 1'b1;
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.rsp_data_o  = sram_rdata_i;
  assign sram_en_o       = cmd_q.en;
  assign sram_rw_o       = cmd_q.rw;
  assign sram_addr_o     = cmd_q.addr;
  assign sram_wdata_o    = cmd_q.wdata;

endmodule

// File: tb/tb_xmpl_sram_arbiter.sv
// tb/tb_xmpl_sram_arbiter.sv - directed scoreboard bench for the SRAM arbiter
module tb_xmpl_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xmpl_sram_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          sram_en;
  logic          sram_rw;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  xmpl_sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .bus          (bus),
    .sram_en_o    (sram_en),
    .sram_addr_o  (sram_addr),
    .sram_rw_o    (sram_rw),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
  );

  function automatic logic [31:0] pre(input logic [11:0] a);
    return {20'hC0DE0, a};
  endfunction

  // SRAM macro model: contents stored XOR a per-address preload pattern
  bit [31:0] mem_x [4096];
  always @(posedge clk) begin
    if (sram_en && sram_rw) mem_x[sram_addr] <= sram_wdata ^ pre(sram_addr);
    if (sram_en && !sram_rw) sram_rdata <= mem_x[sram_addr] ^ pre(sram_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t      sb_q[$];
  int        gnt_idx_q[$];
  int        gnt_cyc_q[$];
  bit [31:0] ref_x [4096];
  bit        mon_on = 1'b0;
  logic          nxt_en = 1'b0;
  logic          nxt_rw = 1'b0;
  logic [AW-1:0] nxt_addr = '0;
  logic [DW-1:0] nxt_wdata = '0;
  logic [N-1:0]  last_rsp_valid = '0;
  logic [DW-1:0] last_rsp_data = '0;
  exp_t          e;

  // Monitor: checks the SRAM command and responses, logs grants, fills the scoreboard
  always begin
    @(negedge clk);
    if (mon_on) begin
      chk("sram_en", 64'(sram_en), 64'(nxt_en));
      if (nxt_en) begin
        chk("sram_rw", 64'(sram_rw), 64'(nxt_rw));
        chk("sram_addr", 64'(sram_addr), 64'(nxt_addr));
        if (nxt_rw) chk("sram_wdata", 64'(sram_wdata), 64'(nxt_wdata));
      end
      if (bus.rsp_valid_o != '0) begin
        last_rsp_valid = bus.rsp_valid_o;
        last_rsp_data  = bus.rsp_data_o;
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_onehot", 64'(bus.rsp_valid_o), 64'(1 << e.idx));
          chk("rsp_data", 64'(bus.rsp_data_o), 64'(e.data));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        chk("rsp_missing", 64'(bus.rsp_valid_o), 64'(1 << e.idx));
      end
      chk("ready_onehot0", 64'($onehot0(bus.req_ready_o)), 64'd1);
      chk("ready_wo_valid", 64'(bus.req_ready_o & ~bus.req_valid_i), 64'd0);
      nxt_en = 1'b0;
      if (rst) begin
        sb_q.delete();
      end else begin
        for (int k = 0; k < N; k++) begin
          if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
            nxt_en    = 1'b1;
            nxt_rw    = bus.req_rw_i[k];
            nxt_addr  = bus.req_addr_i[k*AW +: AW];
            nxt_wdata = bus.req_wdata_i[k*DW +: DW];
            gnt_idx_q.push_back(k);
            gnt_cyc_q.push_back(cyc);
            if (nxt_rw) ref_x[nxt_addr] = nxt_wdata ^ pre(nxt_addr);
            else sb_q.push_back('{k, ref_x[nxt_addr] ^ pre(nxt_addr), cyc + 2});
          end
        end
      end
    end
  end

  int            left   [N];
  int            lockn  [N];
  logic          rw_r   [N];
  logic [AW-1:0] addr_r [N];
  logic [DW-1:0] wd_r   [N];
  int            exp_q[$];

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.req_valid_i[k]           = left[k] > 0;
      bus.req_lock_i[k]            = lockn[k] > 0;
      bus.req_rw_i[k]              = rw_r[k];
      bus.req_addr_i[k*AW +: AW]   = addr_r[k];
      bus.req_wdata_i[k*DW +: DW]  = wd_r[k];
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (!rst && bus.req_valid_i[k] && bus.req_ready_o[k]) begin
        left[k]--;
        if (lockn[k] > 0) lockn[k]--;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += left[k];
    return s;
  endfunction

  task automatic run(input string tag, input int maxc);
    for (int i = 0; i < maxc && pending() > 0; i++) tick();
    chk({tag, "_drained"}, 64'(pending()), 64'd0);
    repeat (4) tick();
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_gnts(input string tag);
    chk({tag, "_gnt_count"}, 64'(gnt_idx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < gnt_idx_q.size(); i++) begin
      chk($sformatf("%s_gnt%0d", tag, i), 64'(gnt_idx_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic clear_log();
    gnt_idx_q.delete();
    gnt_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      left[k] = 0; lockn[k] = 0; rw_r[k] = 1'b0; addr_r[k] = '0; wd_r[k] = '0;
    end
    rst = 1'b1;
    drive();
    @(posedge clk); #1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_sram_rw", 64'(sram_rw), 64'd0);
    chk("rst_sram_wdata", 64'(sram_wdata), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive();
    repeat (2) tick();

    // Round-robin over continuous reads from all three requesters
    clear_log();
    for (int k = 0; k < N; k++) begin
      rw_r[k] = 1'b0; addr_r[k] = 12'(16 * (k + 1)); left[k] = 4;
    end
    drive();
    run("rr", 60);
    exp_q = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
    check_gnts("rr");

    // Move the pointer to 2, then skip the idle requester and wrap
    left[1] = 1;
    drive();
    run("ptr2", 20);
    clear_log();
    left[0] = 1; left[2] = 2;
    drive();
    run("wrap", 20);
    exp_q = '{2, 0, 2};
    check_gnts("wrap");

    // Write then read back at the top address
    rw_r[1] = 1'b1; addr_r[1] = 12'hFFF; wd_r[1] = 32'hDEADBEEF; left[1] = 1;
    drive();
    run("wr", 20);
    rw_r[1] = 1'b0; left[1] = 1;
    drive();
    run("rd", 20);
    chk("wr_rd_data", 64'(last_rsp_data), 64'h0000_0000_DEAD_BEEF);
    chk("wr_rd_valid", 64'(last_rsp_valid), 64'b010);

    // Locked burst longer than LOCK_MAX with a competing requester
    clear_log();
    rw_r[0] = 1'b0; addr_r[0] = 12'h010; left[0] = 12; lockn[0] = 12;
    rw_r[1] = 1'b1; addr_r[1] = 12'h040; wd_r[1] = 32'h1234_5678; left[1] = 1;
    drive();
    run("lock", 60);
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    check_gnts("lock");
    if (gnt_cyc_q.size() >= 9) chk("lock_exit_gap", 64'(gnt_cyc_q[8] - gnt_cyc_q[7]), 64'd1);

    // Owner drops valid right after locking
    clear_log();
    rw_r[0] = 1'b0; addr_r[0] = 12'h040; left[0] = 1;
    rw_r[2] = 1'b0; addr_r[2] = 12'h030; left[2] = 1; lockn[2] = 1;
    drive();
    run("drop", 20);
    exp_q = '{2, 0};
    check_gnts("drop");
    if (gnt_cyc_q.size() >= 2) chk("drop_gap", 64'(gnt_cyc_q[1] - gnt_cyc_q[0]), 64'd2);

    // Reset in the middle of a locked read burst
    clear_log();
    rw_r[1] = 1'b0; addr_r[1] = 12'h020; left[1] = 8; lockn[1] = 8;
    rw_r[2] = 1'b0; addr_r[2] = 12'h030; left[2] = 2;
    drive();
    for (int i = 0; i < 20 && gnt_idx_q.size() < 3; i++) tick();
    chk("rstb_pre_beats", 64'(gnt_idx_q.size() >= 3), 64'd1);
    if (gnt_idx_q.size() >= 1) chk("rstb_owner", 64'(gnt_idx_q[0]), 64'd1);
    rst = 1'b1;
    rw_r[0] = 1'b0; addr_r[0] = 12'h010; left[0] = 1;
    drive();
    clear_log();
    @(posedge clk); #1;
    rst = 1'b0;
    drive();
    sample();
    chk("rstb_sram_en", 64'(sram_en), 64'd0);
    chk("rstb_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    advance();
    run("rstb", 60);
    chk("rstb_any_gnt", 64'(gnt_idx_q.size() > 0), 64'd1);
    if (gnt_idx_q.size() > 0) chk("rstb_first_gnt", 64'(gnt_idx_q[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xmpl_sram_arbiter.md
# xmpl_sram_arbiter

- Arbitrates one single-port 12-bit-address, 32-bit SRAM between `NUM_REQ` requesters (index 0 riscv core, 1 DSP FSM, 2 DSP filter-coefficient loader).
- Sits between the requesters and the SRAM macro; drives the SRAM enable/address/rw/data bus.
- Round-robin fairness, plus optional locked bursts bounded by `LOCK_MAX` beats.
- Returns read data to the issuing requester at fixed latency.

## Interface
- `NUM_REQ`, 3, number of requesters (2..8)
- `ADDR_W`, 12, SRAM address width
- `DATA_W`, 32, SRAM data width
- `LOCK_MAX`, 8, max beats in one locked burst (2..255)

- `clk_i`  in  1  single clock
- `reset_i`  in  1  synchronous, active-high reset
- `req_valid_i`  in  NUM_REQ  per-requester command valid
- `req_ready_o`  out  NUM_REQ  per-requester accept, at most one bit set
- `req_rw_i`  in  NUM_REQ  1 = write, 0 = read
- `req_lock_i`  in  NUM_REQ  1 = keep grant for the next beat
- `req_addr_i`  in  NUM_REQ*ADDR_W  packed addresses, requester k at `[k*ADDR_W +: ADDR_W]`
- `req_wdata_i`  in  NUM_REQ*DATA_W  packed write data
- `rsp_valid_o`  out  NUM_REQ  read-data valid, one-hot
- `rsp_data_o`  out  DATA_W  read data, shared by all requesters
- `sram_en_o`  out  1  SRAM access enable
- `sram_addr_o`  out  ADDR_W  SRAM address
- `sram_rw_o`  out  1  1 = write
- `sram_wdata_o`  out  DATA_W  SRAM write data
- `sram_rdata_i`  in  DATA_W  SRAM read data, valid the cycle after a read enable

## Operation
- **Handshake:** a beat transfers when `req_valid_i[k] & req_ready_o[k]`.
  - Once valid is raised, the requester holds valid and its payload stable until ready.
  - `req_ready_o` is combinational from `req_valid_i`, the pointer and the FSM state.
- **State machine `IDLE` / `LOCKED`:**
  - `IDLE`: winner is the first valid requester at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
    - Accepted beat with lock=0: `rr_ptr` ← winner+1 (mod NUM_REQ).
    - Accepted beat with lock=1: go to `LOCKED`, owner ← winner, `beat_cnt` ← 1.
  - `LOCKED`: only the owner can be granted; all other requesters see ready=0.
    - Owner beat with lock=1 and `beat_cnt`+1 < `LOCK_MAX`: stay, `beat_cnt`++.
    - Owner beat with lock=0: go to `IDLE`, `rr_ptr` ← owner+1.
    - Owner beat that is the `LOCK_MAX`-th beat: forced exit to `IDLE`, `rr_ptr` ← owner+1. The lock bit is ignored.
    - Owner valid=0 in any `LOCKED` cycle: release to `IDLE` with no grant that cycle, `rr_ptr` ← owner+1.
- **SRAM command:** the accepted beat is registered into `sram_*` outputs.
  - With no accepted beat, `sram_en_o` = 0; addr, rw and wdata hold their last values.
- **Read return:** a read issued with `sram_en_o`=1, `sram_rw_o`=0 sets `rsp_valid_o[owner]` in the next cycle.
  - `rsp_data_o` = `sram_rdata_i`, passed through combinationally.
  - Writes produce no response.
- Arbiter stays fully pipelined: one beat can be accepted every cycle, reads and writes freely interleaved.
- Locked beats may mix reads and writes.

## Timing
- **Reset values:** all outputs 0; `rr_ptr` = 0, state `IDLE`, `beat_cnt` = 0, read-in-flight tag cleared.
- **Latency:**
  - Beat accepted in cycle N → `sram_en_o` = 1 in N+1.
  - Read data on `rsp_valid_o` / `rsp_data_o` in N+2.
  - Throughput is 1 beat/cycle.
- **Simultaneous events:** multiple valids resolve by round-robin. The owner's release and a new winner's grant never occur in the same cycle; re-arbitration happens the cycle after release.
- **Pointer wrap:** winner `NUM_REQ`-1 sets `rr_ptr` to 0.
- **Reset mid-operation:**
  - Reset asserted in cycle R: `sram_en_o` and `rsp_valid_o` are 0 in R+1.
  - Reads in flight are dropped with no response.
  - Lock state is cleared.
- **No valid:** ready = 0, `sram_en_o` = 0, pointer unchanged.

## Structure
- **Package `xmpl_sram_pkg`:**
  - `SRAM_ADDR_W` = 12 and `SRAM_DATA_W` = 32 constants.
  - `arb_state_e` enum {`IDLE`, `LOCKED`}.
  - `sram_cmd_t` struct {en, rw, addr, wdata}.
- **Sub-module `xmpl_rr_picker`:** combinational one-hot round-robin pick of `NUM_REQ` bits from a start pointer, plus a `found` flag.
- Arbiter owns the FSM, `beat_cnt`, `rr_ptr`, command register and read-tag pipeline.

## Test plan
- **Round-robin:** all three requesters issue continuous reads to 0x010/0x020/0x030 → grants in order 0,1,2,0,…; each `rsp_valid_o` bit arrives 2 cycles after its accept with that address's preloaded data.
- **Wrap and skip:** `rr_ptr` = 2, only requesters 0 and 2 valid → grant 2, then 0, then 2.
- **Write then read:** requester 1 writes 0xDEADBEEF to 0xFFF, then reads 0xFFF → `rsp_data_o` = 0xDEADBEEF, `rsp_valid_o` = 3'b010.
- **Forced lock exit:** requester 0 holds lock=1 for 12 beats with requester 1 valid → beats 1–8 go to requester 0, cycle 9 grants requester 1, requester 0 resumes afterwards.
- **Owner drop:** requester 2 locks, then drops valid for 1 cycle → no grant that cycle, next cycle grants requester 0.
- **Reset mid-burst:** reset during a locked read burst → no `rsp_valid_o` after reset; state `IDLE`, `rr_ptr` = 0, first post-reset grant goes to requester 0.
